// File: rtl/sbqm_pkg.sv
// sbqm_pkg
//   Shared definitions for the multi-teller queue manager: default parameter
//   values, width helper functions and the wait-time divider state encoding.
//   Optional feature macro used by the other files: SBQM_STATS_EN.
package sbqm_pkg;

    localparam int DEF_DEPTH       = 7;
    localparam int DEF_MAX_TELLERS = 3;
    localparam int DEF_T_SERVICE   = 3;
    localparam int DEF_SYNC_STAGES = 2;

    // Occupancy width: holds 0..depth.
    function automatic int cnt_w(input int depth);
        return (depth > 0) ? $clog2(depth + 1) : 1;
    endfunction

    // Teller-count width: holds 0..max_tellers.
    function automatic int tel_w(input int max_tellers);
        return (max_tellers > 0) ? $clog2(max_tellers + 1) : 1;
    endfunction

    // Wait-time width: holds the largest numerator T*(DEPTH+MAX_TELLERS-1),
    // which also bounds every quotient since the divisor is at least 1.
    function automatic int wait_w(input int depth, input int max_tellers, input int t_service);
        int w;
        w = $clog2(t_service * (depth + max_tellers - 1) + 1);
        return (w < 2) ? 2 : w;
    endfunction

    typedef enum logic {
        IDLE = 1'b0,
        DIV  = 1'b1
    } div_state_e;

endpackage

// File: rtl/sbqm_multi_teller_if.sv
// sbqm_multi_teller_if
//   Bundles the sensor/teller inputs and the status outputs of the queue
//   manager.
//   master: door-sensor front-end / display side (drives sensors, tcount, err_clr)
//   slave : sbqm_multi_teller (drives pcount, wtime, flags)
//   With SBQM_STATS_EN defined, served_total and peak_pcount are added.
interface sbqm_multi_teller_if
    import sbqm_pkg::*;
#(
    parameter int DEPTH       = DEF_DEPTH,
    parameter int MAX_TELLERS = DEF_MAX_TELLERS,
    parameter int T_SERVICE   = DEF_T_SERVICE
) ();

    localparam int CW = cnt_w(DEPTH);
    localparam int TW = tel_w(MAX_TELLERS);
    localparam int WW = wait_w(DEPTH, MAX_TELLERS, T_SERVICE);

    logic          sensor_a;
    logic          sensor_b;
    logic [TW-1:0] tcount;
    logic          err_clr;
    logic [CW-1:0] pcount;
    logic [WW-1:0] wtime;
    logic          wtime_valid;
    logic          full;
    logic          empty;
    logic          overflow_err;
    logic          underflow_err;
    logic          teller_err;
`ifdef SBQM_STATS_EN
    logic [15:0]   served_total;
    logic [CW-1:0] peak_pcount;

    modport master (
        output sensor_a, sensor_b, tcount, err_clr,
        input  pcount, wtime, wtime_valid, full, empty,
               overflow_err, underflow_err, teller_err,
               served_total, peak_pcount
    );
    modport slave (
        input  sensor_a, sensor_b, tcount, err_clr,
        output pcount, wtime, wtime_valid, full, empty,
               overflow_err, underflow_err, teller_err,
               served_total, peak_pcount
    );
`else
    modport master (
        output sensor_a, sensor_b, tcount, err_clr,
        input  pcount, wtime, wtime_valid, full, empty,
               overflow_err, underflow_err, teller_err
    );
    modport slave (
        input  sensor_a, sensor_b, tcount, err_clr,
        output pcount, wtime, wtime_valid, full, empty,
               overflow_err, underflow_err, teller_err
    );
`endif

endinterface

// File: rtl/sbqm_wait_calc.sv
// sbqm_wait_calc
//   Computes W = T_SERVICE*(pcount+tcount-1)/tcount with a restoring divider
//   producing one quotient bit per clock (WW clocks per result).
//   Ports:
//     clk, rst       clock, asynchronous active-low reset
//     start          operands changed while IDLE
//     abort          operands changed while busy: drop the division and restart
//     pcount/tcount  current operands (tcount is the registered copy)
//     teller_bad     tcount is zero or above MAX_TELLERS
//     busy           a division is in flight
//     done           one-cycle strobe: result is valid this cycle
//     result         wait time to load when done is high
module sbqm_wait_calc
    import sbqm_pkg::*;
#(
    parameter  int DEPTH       = DEF_DEPTH,
    parameter  int MAX_TELLERS = DEF_MAX_TELLERS,
    parameter  int T_SERVICE   = DEF_T_SERVICE,
    localparam int CW          = cnt_w(DEPTH),
    localparam int TW          = tel_w(MAX_TELLERS),
    localparam int WW          = wait_w(DEPTH, MAX_TELLERS, T_SERVICE),
    localparam int NW          = WW + TW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic [CW-1:0] pcount,
    input  logic [TW-1:0] tcount,
    input  logic          teller_bad,
    output logic          busy,
    output logic          done,
    output logic [WW-1:0] result
);

    localparam int KW = (WW > 1) ? $clog2(WW) : 1;

    div_state_e    state_q, state_d;
    logic [WW-1:0] quo_q, quo_step;
    logic [TW-1:0] rem_q, rem_step, dvs_q;
    logic [KW-1:0] step_q;
    logic [NW-1:0] numer;
    logic [TW:0]   trial;
    logic          special, load;
    logic [WW-1:0] special_val;

    assign numer       = NW'(T_SERVICE) * (NW'(pcount) + NW'(tcount) - NW'(1));
    assign special     = (pcount == '0) || teller_bad;
    assign special_val = (pcount == '0) ? '0 : '1;
    assign busy        = (state_q == DIV);

    // One restoring step: bring down the next dividend bit, subtract if it fits.
    assign trial = {rem_q, quo_q[WW-1]};

    // NOTE: every signal written in an always_comb gets a default first, so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        rem_step = trial[TW-1:0];
        quo_step = {quo_q[WW-2:0], 1'b0};
        if (trial >= {1'b0, dvs_q}) begin
            rem_step    = TW'(trial - {1'b0, dvs_q});
            quo_step[0] = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        done    = 1'b0;
        result  = special_val;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (special) begin
                        done = 1'b1;
                    end else begin
                        load    = 1'b1;
                        state_d = DIV;
                    end
                end
            end
            DIV: begin
                if (abort) begin
                    if (special) begin
                        done    = 1'b1;
                        state_d = IDLE;
                    end else begin
                        load = 1'b1;
                    end
                end else if (step_q == KW'(WW - 1)) begin
                    done    = 1'b1;
                    result  = quo_step;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values of the others.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            quo_q   <= '0;
            rem_q   <= '0;
            dvs_q   <= '0;
            step_q  <= '0;
        end else begin
            state_q <= state_d;
            if (load) begin
                // The numerator's top TW bits are always zero (below the
                // divisor), so they seed the remainder and only WW steps remain.
                rem_q  <= numer[NW-1:WW];
                quo_q  <= numer[WW-1:0];
                dvs_q  <= tcount;
                step_q <= '0;
            end else if (state_q == DIV) begin
                rem_q  <= rem_step;
                quo_q  <= quo_step;
                step_q <= step_q + KW'(1);
            end
        end
    end

endmodule

// File: rtl/sbqm_multi_teller.sv
// sbqm_multi_teller
//   Queue manager for a multi-teller bank. Synchronises the entry/exit door
//   sensors, keeps the occupancy count with full/empty and sticky error flags,
//   and drives an estimated wait time from the sbqm_wait_calc divider.
//   Ports:
//     clk   system clock
//     rst   asynchronous active-low reset
//     bus   sbqm_multi_teller_if.slave: sensor_a/sensor_b/tcount/err_clr in;
//           pcount, wtime, wtime_valid, full, empty, overflow_err,
//           underflow_err, teller_err out
//   Optional: SBQM_STATS_EN adds served_total and peak_pcount on bus.
module sbqm_multi_teller
    import sbqm_pkg::*;
#(
    parameter int DEPTH       = DEF_DEPTH,
    parameter int MAX_TELLERS = DEF_MAX_TELLERS,
    parameter int T_SERVICE   = DEF_T_SERVICE,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic                clk,
    input  logic                rst,
    sbqm_multi_teller_if.slave  bus
);

    localparam int CW = cnt_w(DEPTH);
    localparam int TW = tel_w(MAX_TELLERS);
    localparam int WW = wait_w(DEPTH, MAX_TELLERS, T_SERVICE);

    logic [SYNC_STAGES-1:0] sync_a, sync_b;
    logic                   prev_a, prev_b;
    logic                   entry, leave;

    logic [CW-1:0] pcount_q, pcount_d, pcount_seen;
    logic          full_q, empty_q, ovf_q, udf_q;
    logic          ovf_evt, udf_evt, dec_evt;
    logic [TW-1:0] tcount_q, tcount_seen;
    logic          teller_bad, changed;

    logic          calc_busy, calc_done;
    logic [WW-1:0] calc_result;
    logic [WW-1:0] wtime_q;
    logic          valid_q;

    // Sensor synchronisers; sync_x[0] samples the raw level.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_a <= '0;
            sync_b <= '0;
            prev_a <= 1'b0;
            prev_b <= 1'b0;
        end else begin
            sync_a <= {sync_a[SYNC_STAGES-2:0], bus.sensor_a};
            sync_b <= {sync_b[SYNC_STAGES-2:0], bus.sensor_b};
            prev_a <= sync_a[SYNC_STAGES-1];
            prev_b <= sync_b[SYNC_STAGES-1];
        end
    end

    assign entry = sync_a[SYNC_STAGES-1] & ~prev_a;
    assign leave = sync_b[SYNC_STAGES-1] & ~prev_b;

    // Simultaneous entry and exit cancel, even at full or empty.
    always_comb begin
        pcount_d = pcount_q;
        ovf_evt  = 1'b0;
        udf_evt  = 1'b0;
        dec_evt  = 1'b0;
        case ({entry, leave})
            2'b10: begin
                if (full_q) ovf_evt  = 1'b1;
                else        pcount_d = pcount_q + CW'(1);
            end
            2'b01: begin
                if (empty_q) begin
                    udf_evt = 1'b1;
                end else begin
                    pcount_d = pcount_q - CW'(1);
                    dec_evt  = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pcount_q    <= '0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            ovf_q       <= 1'b0;
            udf_q       <= 1'b0;
            tcount_q    <= '0;
            pcount_seen <= '0;
            tcount_seen <= '0;
        end else begin
            pcount_q    <= pcount_d;
            full_q      <= (pcount_d == CW'(DEPTH));
            empty_q     <= (pcount_d == '0);
            // A new error event outranks a clear in the same cycle.
            ovf_q       <= ovf_evt | (ovf_q & ~bus.err_clr);
            udf_q       <= udf_evt | (udf_q & ~bus.err_clr);
            tcount_q    <= bus.tcount;
            pcount_seen <= pcount_q;
            tcount_seen <= tcount_q;
        end
    end

    assign teller_bad = (tcount_q == '0) || ({1'b0, tcount_q} > (TW+1)'(MAX_TELLERS));
    assign changed    = (pcount_q != pcount_seen) || (tcount_q != tcount_seen);

    sbqm_wait_calc #(
        .DEPTH       (DEPTH),
        .MAX_TELLERS (MAX_TELLERS),
        .T_SERVICE   (T_SERVICE)
    ) u_wait_calc (
        .clk        (clk),
        .rst        (rst),
        .start      (changed & ~calc_busy),
        .abort      (changed & calc_busy),
        .pcount     (pcount_q),
        .tcount     (tcount_q),
        .teller_bad (teller_bad),
        .busy       (calc_busy),
        .done       (calc_done),
        .result     (calc_result)
    );

    // wtime holds its last result until a new one completes; valid drops as
    // soon as a new computation is kicked off unless it finishes immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wtime_q <= '0;
            valid_q <= 1'b1;
        end else if (calc_done) begin
            wtime_q <= calc_result;
            valid_q <= 1'b1;
        end else if (changed) begin
            valid_q <= 1'b0;
        end
    end

`ifdef SBQM_STATS_EN
    logic [15:0]   served_q;
    logic [CW-1:0] peak_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            served_q <= '0;
            peak_q   <= '0;
        end else begin
            served_q <= served_q + 16'(dec_evt);
            if (bus.err_clr)          peak_q <= pcount_q;
            else if (pcount_q > peak_q) peak_q <= pcount_q;
        end
    end

    assign bus.served_total = served_q;
    assign bus.peak_pcount  = peak_q;
`endif

    assign bus.pcount        = pcount_q;
    assign bus.full          = full_q;
    assign bus.empty         = empty_q;
    assign bus.overflow_err  = ovf_q;
    assign bus.underflow_err = udf_q;
    assign bus.wtime         = wtime_q;
    assign bus.wtime_valid   = valid_q;
    assign bus.teller_err    = (bus.tcount == '0) ||
                               ({1'b0, bus.tcount} > (TW+1)'(MAX_TELLERS));

endmodule

// File: tb/tb_sbqm_multi_teller.sv
// tb_sbqm_multi_teller
//   Directed bench for sbqm_multi_teller (DEPTH=7, MAX_TELLERS=3, T_SERVICE=3,
//   SYNC_STAGES=2). A small reference model predicts pcount, flags and wait
//   times; expected values are queued when stimulus is driven and popped when
//   the DUT output is sampled.
module tb_sbqm_multi_teller;
    import sbqm_pkg::*;

    localparam int DEPTH       = 7;
    localparam int MAX_TELLERS = 3;
    localparam int T_SERVICE   = 3;
    localparam int SYNC_STAGES = 2;
    localparam int TW          = tel_w(MAX_TELLERS);
    localparam int WW          = wait_w(DEPTH, MAX_TELLERS, T_SERVICE);

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    sbqm_multi_teller_if #(
        .DEPTH(DEPTH), .MAX_TELLERS(MAX_TELLERS), .T_SERVICE(T_SERVICE)
    ) bus ();

    sbqm_multi_teller #(
        .DEPTH(DEPTH), .MAX_TELLERS(MAX_TELLERS),
        .T_SERVICE(T_SERVICE), .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;
    int exp_p_q[$];
    int exp_w_q[$];

    int model_p, model_t, model_served, model_peak;
    bit model_ovf, model_udf;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int model_w(input int p, input int t);
        if (p == 0) return 0;
        if (t == 0 || t > MAX_TELLERS) return (1 << WW) - 1;
        return (T_SERVICE * (p + t - 1)) / t;
    endfunction

    task automatic model_reset();
        model_p      = 0;
        model_served = 0;
        model_peak   = 0;
        model_ovf    = 1'b0;
        model_udf    = 1'b0;
    endtask

    // Raise the selected sensors, check pcount SYNC_STAGES+1 clocks after the
    // sampled edge, then drop them long enough to re-arm edge detection.
    task automatic pulse(input bit a, input bit b);
        if (a && !b) begin
            if (model_p < DEPTH) model_p++;
            else                 model_ovf = 1'b1;
        end else if (b && !a) begin
            if (model_p > 0) begin
                model_p--;
                model_served++;
            end else begin
                model_udf = 1'b1;
            end
        end
        if (model_p > model_peak) model_peak = model_p;
        exp_p_q.push_back(model_p);
        @(negedge clk);
        bus.sensor_a = a;
        bus.sensor_b = b;
        @(posedge clk);
        repeat (SYNC_STAGES) @(posedge clk);
        #1 check("pcount", 32'(bus.pcount), 32'(exp_p_q.pop_front()));
        @(negedge clk);
        bus.sensor_a = 1'b0;
        bus.sensor_b = 1'b0;
        repeat (SYNC_STAGES + 1) @(negedge clk);
    endtask

    task automatic clear_errors();
        @(negedge clk);
        bus.err_clr = 1'b1;
        model_ovf  = 1'b0;
        model_udf  = 1'b0;
        model_peak = model_p;
        @(negedge clk);
        bus.err_clr = 1'b0;
        #1;
        check("overflow_err_clr", 32'(bus.overflow_err), 32'(model_ovf));
        check("underflow_err_clr", 32'(bus.underflow_err), 32'(model_udf));
    endtask

    task automatic set_tcount(input int t);
        @(negedge clk);
        bus.tcount = TW'(t);
        model_t    = t;
        repeat (3) @(posedge clk);
        #1;
    endtask

    // Bounded wait for wtime_valid, then compare against the queued result.
    task automatic wait_result(input string tag);
        int n;
        n = 0;
        while (bus.wtime_valid !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_valid"}, 32'(bus.wtime_valid), 32'd1);
        check({tag, "_wtime"}, 32'(bus.wtime), 32'(exp_w_q.pop_front()));
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_pcount"}, 32'(bus.pcount), 32'd0);
        check({tag, "_empty"}, 32'(bus.empty), 32'd1);
        check({tag, "_full"}, 32'(bus.full), 32'd0);
        check({tag, "_wtime"}, 32'(bus.wtime), 32'd0);
        check({tag, "_valid"}, 32'(bus.wtime_valid), 32'd1);
        check({tag, "_ovf"}, 32'(bus.overflow_err), 32'd0);
        check({tag, "_udf"}, 32'(bus.underflow_err), 32'd0);
`ifdef SBQM_STATS_EN
        check({tag, "_served"}, 32'(bus.served_total), 32'd0);
        check({tag, "_peak"}, 32'(bus.peak_pcount), 32'd0);
`endif
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.sensor_a = 1'b0;
        bus.sensor_b = 1'b0;
        bus.tcount   = TW'(2);
        bus.err_clr  = 1'b0;
        model_t      = 2;
        model_reset();
        repeat (3) @(posedge clk);
        #1 check_reset_state("por");
        @(negedge clk);
        rst = 1'b1;

        // 1: start a division, assert reset mid-DIV, then count three entries.
        pulse(1'b1, 1'b0);
        check("t1_in_div_valid", 32'(bus.wtime_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1 check_reset_state("rst_mid_div");
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (3) pulse(1'b1, 1'b0);

        // 2: pcount=3, tcount=2 -> 6; then abort a tcount=1 division with tcount=3.
        exp_w_q.push_back(model_w(model_p, model_t));
        wait_result("t2_p3_t2");
        set_tcount(1);
        check("t2_div_valid", 32'(bus.wtime_valid), 32'd0);
        check("t2_hold_wtime", 32'(bus.wtime), 32'(model_w(3, 2)));
        @(negedge clk);
        bus.tcount = TW'(3);
        model_t    = 3;
        exp_w_q.push_back(model_w(model_p, model_t));
        repeat (3) @(posedge clk);
        #1 check("t2_restart_valid", 32'(bus.wtime_valid), 32'd0);
        wait_result("t2_abort");

        // 3: fill to DEPTH, one more entry overflows; clear the flag.
        while (model_p < DEPTH) pulse(1'b1, 1'b0);
        check("t3_full", 32'(bus.full), 32'd1);
        check("t3_empty", 32'(bus.empty), 32'd0);
        pulse(1'b1, 1'b0);
        check("t3_overflow", 32'(bus.overflow_err), 32'(model_ovf));
        check("t3_full_hold", 32'(bus.full), 32'd1);
        clear_errors();
        exp_w_q.push_back(model_w(model_p, model_t));
        wait_result("t3_p7_t3");

        // 5a: simultaneous entry+exit at full.
        pulse(1'b1, 1'b1);
        check("t5_full_ovf", 32'(bus.overflow_err), 32'd0);
        check("t5_full_udf", 32'(bus.underflow_err), 32'd0);

        // 4: drain to empty, one more exit underflows.
        while (model_p > 0) pulse(1'b0, 1'b1);
        check("t4_empty", 32'(bus.empty), 32'd1);
        pulse(1'b0, 1'b1);
        check("t4_underflow", 32'(bus.underflow_err), 32'(model_udf));
        exp_w_q.push_back(model_w(model_p, model_t));
        wait_result("t4_empty");
        clear_errors();

        // 5b: simultaneous entry+exit at empty.
        pulse(1'b1, 1'b1);
        check("t5_empty_ovf", 32'(bus.overflow_err), 32'd0);
        check("t5_empty_udf", 32'(bus.underflow_err), 32'd0);
        check("t5_empty_flag", 32'(bus.empty), 32'd1);

        // 6: 4 entries, 2 exits, then no tellers.
        repeat (4) pulse(1'b1, 1'b0);
        repeat (2) pulse(1'b0, 1'b1);
        @(negedge clk);
        bus.tcount = TW'(0);
        model_t    = 0;
        #1 check("t6_teller_err", 32'(bus.teller_err), 32'd1);
        exp_w_q.push_back(model_w(model_p, model_t));
        repeat (3) @(posedge clk);
        #1;
        wait_result("t6_no_tellers");
`ifdef SBQM_STATS_EN
        check("t6_served_total", 32'(bus.served_total), 32'(model_served));
        check("t6_peak_pcount", 32'(bus.peak_pcount), 32'(model_peak));
`endif
        set_tcount(2);
        check("t6_teller_ok", 32'(bus.teller_err), 32'd0);
        exp_w_q.push_back(model_w(model_p, model_t));
        wait_result("t6_p2_t2");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
